hmc_rf_responder: RTL and testbench
===================================

HMC_RF_RESPONDER -- requirements
Module: hmc_rf_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, register address width.
REQ-002 SHALL have parameter WRITE_DATA_WIDTH, default 64, write bus width (>=32).
REQ-003 SHALL have parameter READ_DATA_WIDTH, default 64, read bus width (>=32).
REQ-004 SHALL have parameter WAIT_CYCLES, default 0, extra access latency cycles, legal range 0..15.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port res  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port address  input  ADDR_WIDTH  register address, sampled with wen/ren.
REQ-008 SHALL have port wen  input  1  write request, single-cycle pulse.
REQ-009 SHALL have port ren  input  1  read request, single-cycle pulse.
REQ-010 SHALL have port write_data  input  WRITE_DATA_WIDTH  write payload, sampled with wen.
REQ-011 SHALL have port read_data  output  READ_DATA_WIDTH  read result, valid only while access_done.
REQ-012 SHALL have port access_done  output  1  one-cycle completion pulse per accepted request.
REQ-013 SHALL have port invalid_address  output  1  error flag, asserted only together with access_done.
REQ-014 SHALL have port status_i  input  32  live hardware status, sampled on STATUS read.
REQ-015 SHALL have port event_i  input  1  event strobe for EVENT_CNT.
REQ-016 SHALL have port control_o  output  WRITE_DATA_WIDTH  current CONTROL register contents.

Function
REQ-017 SHALL implement map: 0 CONTROL RW; 1 STATUS RO; 2 SCRATCH RW; 3 EVENT_CNT RW (32 bit); 4 ACCESS_CNT RO (32 bit); all other addresses invalid.
REQ-018 SHALL use FSM IDLE -> WAIT -> DONE -> IDLE; IDLE->WAIT when wen or ren sampled; WAIT holds WAIT_CYCLES cycles (skipped when 0); DONE lasts exactly one cycle.
REQ-019 SHALL capture address, write_data, wen, ren in the IDLE acceptance cycle; request sampled at cycle T gives access_done at T+1+WAIT_CYCLES.
REQ-020 SHALL ignore wen/ren while not in IDLE (no queueing, no second access_done).
REQ-021 SHALL commit writes on the edge that asserts access_done; new value readable by any later access and visible on control_o from that cycle.
REQ-022 SHALL truncate writes to register width and zero-extend reads to READ_DATA_WIDTH; read_data SHALL be 0 whenever access_done is low.
REQ-023 SHALL treat writes to STATUS and ACCESS_CNT as valid no-ops (no invalid_address, contents unchanged).
REQ-024 SHALL complete an invalid-address access with access_done=1, invalid_address=1, read_data=0, no state change.
REQ-025 SHALL treat simultaneous wen and ren as invalid: access_done=1, invalid_address=1, no write.
REQ-026 SHALL increment ACCESS_CNT by 1 at each access_done without invalid_address, wrapping 0xFFFFFFFF->0.
REQ-027 SHALL increment EVENT_CNT on each cycle event_i=1, saturating at 0xFFFFFFFF; write commit in the same cycle wins over the increment.

Reset
REQ-028 SHALL, with res=1 at a rising edge, force FSM to IDLE and clear CONTROL, SCRATCH, EVENT_CNT, ACCESS_CNT, read_data, access_done, invalid_address, control_o to 0.
REQ-029 SHALL abort an in-flight access on reset with no access_done and no register update.
REQ-030 SHALL ignore wen/ren and event_i in cycles where res=1.

Configuration
REQ-031 SHALL honour macro HMC_RF_EVENT_COUNTER_EN: defined -> EVENT_CNT implemented per REQ-017/REQ-027; undefined -> no counter logic, address 3 invalid per REQ-024, event_i unused.

Verification
REQ-032 SHALL cover: WAIT_CYCLES=0, wen addr 2 data 0xDEADBEEF_CAFEF00D at T -> access_done at T+1, invalid_address=0; ren addr 2 -> read_data 0xDEADBEEF_CAFEF00D.
REQ-033 SHALL cover: WAIT_CYCLES=3, ren addr 1 with status_i=0x12345678 -> access_done exactly at T+4, read_data 0x0000000012345678, single-cycle pulse.
REQ-034 SHALL cover: ren addr 9 -> access_done=1, invalid_address=1, read_data=0, ACCESS_CNT unchanged; wen and ren together at addr 0 -> invalid, CONTROL unchanged.
REQ-035 SHALL cover: macro defined, write EVENT_CNT=0xFFFFFFFE, 3 event_i pulses -> read 0xFFFFFFFF; write 5 coinciding with event_i -> read 5.
REQ-036 SHALL cover: WAIT_CYCLES=5, wen addr 0 data 0xFF, res pulsed at T+2 -> no access_done, control_o=0, subsequent ren addr 4 returns 0.
REQ-037 SHALL cover: second wen issued during WAIT -> ignored, exactly one access_done, register holds first write data.

Source files
------------

// File: rtl/hmc_rf_responder.sv
// hmc_rf_responder: small register file with a fixed-latency access FSM.
// Map: 0 CONTROL (RW), 1 STATUS (RO, live status_i), 2 SCRATCH (RW),
//      3 EVENT_CNT (RW, 32 bit, only with HMC_RF_EVENT_COUNTER_EN),
//      4 ACCESS_CNT (RO, 32 bit). Everything else answers invalid_address.
// Optional feature macro: HMC_RF_EVENT_COUNTER_EN (EVENT_CNT at address 3).
//
// Handshake: wen/ren are single-cycle request pulses sampled only in IDLE;
// each accepted request yields exactly one access_done pulse WAIT_CYCLES+1
// cycles later, and read_data/invalid_address are meaningful only while
// access_done is high (read_data is 0 otherwise). Requests seen while busy
// are dropped.
module hmc_rf_responder #(
  parameter int ADDR_WIDTH       = 6,
  parameter int WRITE_DATA_WIDTH = 64,
  parameter int READ_DATA_WIDTH  = 64,
  parameter int WAIT_CYCLES      = 0
) (
  input  logic                        clk,
  input  logic                        res,
  input  logic [ADDR_WIDTH-1:0]       address,
  input  logic                        wen,
  input  logic                        ren,
  input  logic [WRITE_DATA_WIDTH-1:0] write_data,
  output logic [READ_DATA_WIDTH-1:0]  read_data,
  output logic                        access_done,
  output logic                        invalid_address,
  input  logic [31:0]                 status_i,
  input  logic                        event_i,
  output logic [WRITE_DATA_WIDTH-1:0] control_o,
  output logic [1:0]                  state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] A_CONTROL    = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS     = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_SCRATCH    = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_EVENT_CNT  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_ACCESS_CNT = ADDR_WIDTH'(4);

  state_t                        state_q, state_d;
  logic [3:0]                    wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-1:0]         addr_q;
  logic [WRITE_DATA_WIDTH-1:0]   wdata_q;
  logic                          wen_q, ren_q;

  logic [WRITE_DATA_WIDTH-1:0]   control_q, control_d;
  logic [WRITE_DATA_WIDTH-1:0]   scratch_q, scratch_d;
  logic [31:0]                   access_cnt_q, access_cnt_d;
  logic [31:0]                   event_cnt_q, event_cnt_d;

  logic [READ_DATA_WIDTH-1:0]    read_data_q;
  logic                          access_done_q, invalid_q;

  // Access attributes: live inputs in IDLE (zero-wait commit happens on the
  // acceptance edge), captured copies once the FSM has left IDLE.
  logic                          in_idle;
  logic [ADDR_WIDTH-1:0]         acc_addr;
  logic [WRITE_DATA_WIDTH-1:0]   acc_wdata;
  logic                          acc_wen, acc_ren;

  logic                          commit;
  logic                          addr_ok;
  logic                          acc_invalid;
  logic                          do_write;
  logic [READ_DATA_WIDTH-1:0]    rd_val;

  assign in_idle   = (state_q == S_IDLE);
  assign acc_addr  = in_idle ? address    : addr_q;
  assign acc_wdata = in_idle ? write_data : wdata_q;
  assign acc_wen   = in_idle ? wen        : wen_q;
  assign acc_ren   = in_idle ? ren        : ren_q;

  // FSM next-state: IDLE -> (WAIT) -> DONE -> IDLE; commit marks the edge into DONE.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    commit     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wen || ren) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_DONE;
            commit  = 1'b1;
          end else begin
            state_d    = S_WAIT;
            wait_cnt_d = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = S_DONE;
          commit  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address decode and read mux for the access being completed.
  always_comb begin
    addr_ok = 1'b0;
    rd_val  = '0;
    case (acc_addr)
      A_CONTROL: begin
        addr_ok = 1'b1;
        rd_val  = READ_DATA_WIDTH'(control_q);
      end
      A_STATUS: begin
        addr_ok = 1'b1;
        rd_val  = READ_DATA_WIDTH'(status_i);
      end
      A_SCRATCH: begin
        addr_ok = 1'b1;
        rd_val  = READ_DATA_WIDTH'(scratch_q);
      end
`ifdef HMC_RF_EVENT_COUNTER_EN
      A_EVENT_CNT: begin
        addr_ok = 1'b1;
        rd_val  = READ_DATA_WIDTH'(event_cnt_q);
      end
`endif
      A_ACCESS_CNT: begin
        addr_ok = 1'b1;
        rd_val  = READ_DATA_WIDTH'(access_cnt_q);
      end
      default: begin
        addr_ok = 1'b0;
        rd_val  = '0;
      end
    endcase
  end

  // Simultaneous read+write is treated as an invalid access.
  assign acc_invalid = (acc_wen && acc_ren) || !addr_ok;
  assign do_write    = commit && acc_wen && !acc_invalid;

  // Register next values; writes to STATUS/ACCESS_CNT fall through as no-ops.
  always_comb begin
    control_d    = control_q;
    scratch_d    = scratch_q;
    access_cnt_d = access_cnt_q;
    if (do_write && (acc_addr == A_CONTROL)) control_d = acc_wdata;
    if (do_write && (acc_addr == A_SCRATCH)) scratch_d = acc_wdata;
    if (commit && !acc_invalid) access_cnt_d = access_cnt_q + 32'd1;
  end

`ifdef HMC_RF_EVENT_COUNTER_EN
  // Saturating event counter; a committed write in the same cycle wins.
  always_comb begin
    event_cnt_d = event_cnt_q;
    if (do_write && (acc_addr == A_EVENT_CNT)) begin
      event_cnt_d = acc_wdata[31:0];
    end else if (event_i && (event_cnt_q != 32'hFFFF_FFFF)) begin
      event_cnt_d = event_cnt_q + 32'd1;
    end
  end
`else
  logic unused_event;
  assign unused_event = event_i;
  // Counter absent: hold at zero so nothing downstream depends on it.
  always_comb begin
    event_cnt_d = 32'd0;
  end
`endif

  // State, capture, register file and registered response outputs.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= 4'd0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wen_q         <= 1'b0;
      ren_q         <= 1'b0;
      control_q     <= '0;
      scratch_q     <= '0;
      access_cnt_q  <= 32'd0;
      event_cnt_q   <= 32'd0;
      read_data_q   <= '0;
      access_done_q <= 1'b0;
      invalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      if (in_idle && (wen || ren)) begin
        addr_q  <= address;
        wdata_q <= write_data;
        wen_q   <= wen;
        ren_q   <= ren;
      end
      control_q     <= control_d;
      scratch_q     <= scratch_d;
      access_cnt_q  <= access_cnt_d;
      event_cnt_q   <= event_cnt_d;
      access_done_q <= commit;
      invalid_q     <= commit && acc_invalid;
      read_data_q   <= (commit && !acc_invalid && acc_ren) ? rd_val : '0;
    end
  end

  assign read_data       = read_data_q;
  assign access_done     = access_done_q;
  assign invalid_address = invalid_q;
  assign control_o       = control_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_hmc_rf_responder.sv
// Directed bench for hmc_rf_responder: three instances with WAIT_CYCLES of
// 0, 3 and 5, each with its own stimulus signals. Event counter checks follow
// HMC_RF_EVENT_COUNTER_EN.
module tb_hmc_rf_responder;

  logic        clk;
  logic        res_v     [3];
  logic [5:0]  addr_v    [3];
  logic        wen_v     [3];
  logic        ren_v     [3];
  logic [63:0] wdata_v   [3];
  logic [63:0] rdata_v   [3];
  logic        done_v    [3];
  logic        inv_v     [3];
  logic [31:0] status_v  [3];
  logic        ev_v      [3];
  logic [63:0] control_v [3];
  logic [1:0]  state_v   [3];

  int checks   = 0;
  int failures = 0;
  int cnt0     = 0;

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  hmc_rf_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .res(res_v[0]), .address(addr_v[0]), .wen(wen_v[0]), .ren(ren_v[0]),
    .write_data(wdata_v[0]), .read_data(rdata_v[0]), .access_done(done_v[0]),
    .invalid_address(inv_v[0]), .status_i(status_v[0]), .event_i(ev_v[0]),
    .control_o(control_v[0]), .state_o(state_v[0]));

  hmc_rf_responder #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .res(res_v[1]), .address(addr_v[1]), .wen(wen_v[1]), .ren(ren_v[1]),
    .write_data(wdata_v[1]), .read_data(rdata_v[1]), .access_done(done_v[1]),
    .invalid_address(inv_v[1]), .status_i(status_v[1]), .event_i(ev_v[1]),
    .control_o(control_v[1]), .state_o(state_v[1]));

  hmc_rf_responder #(.WAIT_CYCLES(5)) dut5 (
    .clk(clk), .res(res_v[2]), .address(addr_v[2]), .wen(wen_v[2]), .ren(ren_v[2]),
    .write_data(wdata_v[2]), .read_data(rdata_v[2]), .access_done(done_v[2]),
    .invalid_address(inv_v[2]), .status_i(status_v[2]), .event_i(ev_v[2]),
    .control_o(control_v[2]), .state_o(state_v[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request pulse on instance k; waits (bounded) for access_done and
  // samples the response plus the cycle after it.
  task automatic acc_chk(input string tag, input int k, input logic we, input logic re,
                         input logic [5:0] a, input logic [63:0] wd, input logic ev,
                         input int exp_lat, input logic exp_inv, input logic [63:0] exp_rd);
    int          lat;
    logic [63:0] rd, rd_after;
    logic        inv, done_after;
    @(negedge clk);
    wen_v[k] = we; ren_v[k] = re; addr_v[k] = a; wdata_v[k] = wd; ev_v[k] = ev;
    @(negedge clk);
    wen_v[k] = 1'b0; ren_v[k] = 1'b0; ev_v[k] = 1'b0;
    lat = 1;
    while (!done_v[k] && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    rd  = rdata_v[k];
    inv = inv_v[k];
    @(negedge clk);
    done_after = done_v[k];
    rd_after   = rdata_v[k];
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_inv"}, {63'b0, inv}, {63'b0, exp_inv});
    chk({tag, "_rd"}, rd, exp_rd);
    chk({tag, "_pulse"}, {63'b0, done_after}, 64'd0);
    chk({tag, "_rd_idle"}, rd_after, 64'd0);
    if (k == 0 && !exp_inv) cnt0++;
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < 3; i++) begin
      res_v[i] = 1'b1; addr_v[i] = '0; wen_v[i] = 1'b0; ren_v[i] = 1'b0;
      wdata_v[i] = '0; ev_v[i] = 1'b0; status_v[i] = 32'd0;
    end
    status_v[0] = 32'hA5A5_0001;
    status_v[1] = 32'h1234_5678;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) res_v[i] = 1'b0;

    // Reset state
    chk("rst_done", {63'b0, done_v[0]}, 64'd0);
    chk("rst_inv", {63'b0, inv_v[0]}, 64'd0);
    chk("rst_rd", rdata_v[0], 64'd0);
    chk("rst_ctrl", control_v[0], 64'd0);

    // Zero-wait write/read of SCRATCH
    acc_chk("w_scratch", 0, 1, 0, 6'd2, 64'hDEADBEEF_CAFEF00D, 0, 1, 0, 64'd0);
    acc_chk("r_scratch", 0, 0, 1, 6'd2, 64'd0, 0, 1, 0, 64'hDEADBEEF_CAFEF00D);
    acc_chk("r_acnt1", 0, 0, 1, 6'd4, 64'd0, 0, 1, 0, 64'(cnt0));

    // Invalid address leaves ACCESS_CNT alone
    acc_chk("r_bad9", 0, 0, 1, 6'd9, 64'd0, 0, 1, 1, 64'd0);
    acc_chk("r_acnt2", 0, 0, 1, 6'd4, 64'd0, 0, 1, 0, 64'(cnt0));

    // wen+ren together: invalid, CONTROL untouched
    acc_chk("wr_both", 0, 1, 1, 6'd0, 64'h55, 0, 1, 1, 64'd0);
    chk("ctrl_after_both", control_v[0], 64'd0);
    acc_chk("r_ctrl0", 0, 0, 1, 6'd0, 64'd0, 0, 1, 0, 64'd0);

    // CONTROL write shows up on control_o
    acc_chk("w_ctrl", 0, 1, 0, 6'd0, 64'h1234, 0, 1, 0, 64'd0);
    chk("ctrl_o", control_v[0], 64'h1234);
    acc_chk("r_ctrl", 0, 0, 1, 6'd0, 64'd0, 0, 1, 0, 64'h1234);

    // Writes to read-only registers are valid no-ops
    acc_chk("w_status", 0, 1, 0, 6'd1, 64'h99, 0, 1, 0, 64'd0);
    acc_chk("r_status", 0, 0, 1, 6'd1, 64'd0, 0, 1, 0, 64'h0000_0000_A5A5_0001);
    acc_chk("w_acnt", 0, 1, 0, 6'd4, 64'd0, 0, 1, 0, 64'd0);
    acc_chk("r_acnt3", 0, 0, 1, 6'd4, 64'd0, 0, 1, 0, 64'(cnt0));

`ifdef HMC_RF_EVENT_COUNTER_EN
    acc_chk("w_ecnt", 0, 1, 0, 6'd3, 64'hFFFF_FFFE, 0, 1, 0, 64'd0);
    @(negedge clk);
    ev_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    ev_v[0] = 1'b0;
    acc_chk("r_ecnt_sat", 0, 0, 1, 6'd3, 64'd0, 0, 1, 0, 64'h0000_0000_FFFF_FFFF);
    acc_chk("w_ecnt_ev", 0, 1, 0, 6'd3, 64'd5, 1, 1, 0, 64'd0);
    acc_chk("r_ecnt5", 0, 0, 1, 6'd3, 64'd0, 0, 1, 0, 64'd5);
`else
    acc_chk("r_ecnt_absent", 0, 0, 1, 6'd3, 64'd0, 0, 1, 1, 64'd0);
`endif

    // WAIT_CYCLES=3: STATUS read latency and value
    acc_chk("w3_status", 1, 0, 1, 6'd1, 64'd0, 0, 4, 0, 64'h0000_0000_1234_5678);

    // WAIT_CYCLES=3: second write during WAIT is dropped
    pulses = 0;
    @(negedge clk);
    wen_v[1] = 1'b1; addr_v[1] = 6'd2; wdata_v[1] = 64'hAAAA;
    @(negedge clk);
    wen_v[1] = 1'b0;
    if (done_v[1]) pulses++;
    @(negedge clk);
    wen_v[1] = 1'b1; wdata_v[1] = 64'hBBBB;
    if (done_v[1]) pulses++;
    @(negedge clk);
    wen_v[1] = 1'b0;
    if (done_v[1]) pulses++;
    repeat (10) begin
      @(negedge clk);
      if (done_v[1]) pulses++;
    end
    chk("w3_one_done", 64'(pulses), 64'd1);
    acc_chk("w3_r_scratch", 1, 0, 1, 6'd2, 64'd0, 0, 4, 0, 64'hAAAA);

    // WAIT_CYCLES=5: reset in flight aborts the write
    pulses = 0;
    @(negedge clk);
    wen_v[2] = 1'b1; addr_v[2] = 6'd0; wdata_v[2] = 64'hFF;
    @(negedge clk);
    wen_v[2] = 1'b0;
    @(negedge clk);
    res_v[2] = 1'b1;
    @(negedge clk);
    res_v[2] = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done_v[2]) pulses++;
    end
    chk("w5_abort_done", 64'(pulses), 64'd0);
    chk("w5_abort_ctrl", control_v[2], 64'd0);
    acc_chk("w5_r_acnt", 2, 0, 1, 6'd4, 64'd0, 0, 6, 0, 64'd0);
    acc_chk("w5_r_ctrl", 2, 0, 1, 6'd0, 64'd0, 0, 6, 0, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
